mux4_rr_arbiter: RTL and testbench

- **Function:** round-robin arbiter that shares the CMOS 4-to-1 mux between four requesters.
- **Mux drive:** requester *i* owns mux input *i*. The block drives the mux select pins `s0`/`s1` and a one-hot grant.
- **Hold and release:** an owner keeps the mux until it drops its request. Optionally, a hold-limit timer forces release.
- **Placement:** sits directly in front of the `cmos_mux_4to1` instance and is the only driver of its select lines.

---
 rtl/mux_arb_pkg.sv | 15 +
 rtl/mux4_rr_arbiter_pick.sv | 27 ++
 rtl/mux4_rr_arbiter.sv | 111 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared constants and state encoding for the mux round-robin arbiter
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Previous-owner value after reset, so requester 0 is scanned first
   localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

endpackage

// File: rtl/mux4_rr_arbiter_pick.sv
// rtl/mux4_rr_arbiter_pick.sv - combinational round-robin picker (module rr_pick4)
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic [SEL_W-1:0] pick,
   output logic             any
);

   logic [SEL_W-1:0] idx;

   // Scan last+4 down to last+1 so the nearest asserted request after last wins
   always_comb begin
      pick = '0;
      any  = 1'b0;
      idx  = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = last + SEL_W'(k);
         if (req[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin owner of the cmos_mux_4to1 select lines (optional MUX_ARB_TIMEOUT_EN)
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic             s0,
   output logic             s1,
   output logic             busy,
   output logic             expired
);

   if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("MAX_HOLD must be within 1..255");
   end

   state_t           state, state_nxt;
   logic [SEL_W-1:0] owner, owner_nxt;
   logic [SEL_W-1:0] last, last_nxt;
   logic             expired_q, expired_nxt;
   logic [SEL_W-1:0] pick;
   logic             any;

`ifdef MUX_ARB_TIMEOUT_EN
   logic [7:0]       hold_cnt, hold_nxt;
   logic             hold_hit;

   assign hold_hit = (hold_cnt == 8'(MAX_HOLD - 1));
`endif

   rr_pick4 u_pick (
      .req  (req),
      .last (last),
      .pick (pick),
      .any  (any)
   );

   // State register; owner is kept through IDLE so the select pins do not toggle
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner     <= '0;
         last      <= LAST_RST;
         expired_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_cnt  <= '0;
`endif
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         last      <= last_nxt;
         expired_q <= expired_nxt;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_cnt  <= hold_nxt;
`endif
      end
   end

   // Next-state: arbitrate in IDLE, release on dropped request (or hold limit) in BUSY
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      last_nxt    = last;
      expired_nxt = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_nxt    = hold_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (any) begin
               state_nxt = ST_BUSY;
               owner_nxt = pick;
`ifdef MUX_ARB_TIMEOUT_EN
               hold_nxt  = '0;
`endif
            end
         end
         ST_BUSY: begin
            if (!req[owner]) begin
               state_nxt = ST_IDLE;
               last_nxt  = owner;
            end
`ifdef MUX_ARB_TIMEOUT_EN
            else if (hold_hit) begin
               // Forced release; the owner's request stays live but it now ranks last
               state_nxt   = ST_IDLE;
               last_nxt    = owner;
               expired_nxt = 1'b1;
            end else begin
               hold_nxt = hold_cnt + 8'd1;
            end
`endif
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from registers only, so req never reaches an output combinationally
   always_comb begin
      busy    = (state == ST_BUSY);
      grant   = busy ? (N_REQ'(1) << owner) : '0;
      s0      = owner[1];
      s1      = owner[0];
      expired = expired_q;
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard bench for mux4_rr_arbiter against a rule-level model
module tb_mux4_rr_arbiter;

   localparam int TB_MAX_HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
   localparam bit TIMEOUT = 1'b1;
`else
   localparam bit TIMEOUT = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] grant;
      logic [1:0] sel;
      logic       busy;
      logic       expired;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] grant;
   logic       s0, s1, busy, expired;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t mon_a;
   int   n_checks = 0;
   int   n_fail   = 0;

   // model state: owner index or -1 when idle, previous owner, busy cycles so far, select value
   int   m_owner = -1;
   int   m_prev  = 3;
   int   m_held  = 0;
   int   m_sel   = 0;
   logic m_exp   = 1'b0;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .grant   (grant),
      .s0      (s0),
      .s1      (s1),
      .busy    (busy),
      .expired (expired)
   );

   task automatic check_direct(input string name, input bit ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s t=%0t: grant=%b sel=%b%b busy=%b expired=%b",
                  name, $time, grant, s0, s1, busy, expired);
      end
   endtask

   task automatic model_step(input logic r, input logic [3:0] q);
      exp_t e;
      bit   found;
      int   c;
      m_exp = 1'b0;
      if (r) begin
         m_owner = -1;
         m_prev  = 3;
         m_held  = 0;
         m_sel   = 0;
      end else if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            c = (m_prev + k) % 4;
            if (!found && q[c]) begin
               found   = 1'b1;
               m_owner = c;
               m_held  = 1;
               m_sel   = c;
            end
         end
      end else if (!q[m_owner]) begin
         m_prev  = m_owner;
         m_owner = -1;
      end else if (TIMEOUT && m_held >= TB_MAX_HOLD) begin
         m_prev  = m_owner;
         m_owner = -1;
         m_exp   = 1'b1;
      end else begin
         m_held++;
      end
      e.grant   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      e.sel     = 2'(m_sel);
      e.busy    = (m_owner >= 0);
      e.expired = m_exp;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic r, input logic [3:0] q);
      rst = r;
      req = q;
      @(posedge clk);
      model_step(r, q);
      @(negedge clk);
   endtask

   // Monitor: one comparison per clock against the oldest expected response
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {grant, s0, s1, busy, expired};
         n_checks++;
         if (mon_a !== mon_e) begin
            n_fail++;
            $display("FAIL arb_outputs t=%0t: got grant=%b sel=%b busy=%b expired=%b, expected grant=%b sel=%b busy=%b expired=%b",
                     $time, mon_a.grant, mon_a.sel, mon_a.busy, mon_a.expired,
                     mon_e.grant, mon_e.sel, mon_e.busy, mon_e.expired);
         end
      end
   end

   initial begin
      logic [3:0] r;
      logic [3:0] flip;
      int         n_expired;

      // reset with all requesting, then first grant and full rotation
      step(1'b1, 4'b1111);
      step(1'b1, 4'b1111);
      check_direct("reset_state",
                   grant === 4'b0000 && s0 === 1'b0 && s1 === 1'b0 &&
                   busy === 1'b0 && expired === 1'b0);
      for (int i = 0; i < 26; i++) begin
         r = 4'b1111;
         if (m_owner >= 0 && m_held == 3) r[m_owner] = 1'b0;
         step(1'b0, r);
      end

      // make requester 1 the last owner, then 1001 must go to 3 before 0
      step(1'b1, 4'b0000);
      step(1'b0, 4'b0010);
      step(1'b0, 4'b0010);
      step(1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) step(1'b0, 4'b1001);
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0001);
      step(1'b0, 4'b0000);

      // single persistent requester: hold limit behaviour or unlimited hold
      n_expired = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 4'b0100);
         if (expired === 1'b1) n_expired++;
      end
      check_direct("expired_wait", TIMEOUT ? (n_expired > 0) : (n_expired == 0));

      // reset while requester 2 owns the mux, then requester 0 wins
      step(1'b1, 4'b0100);
      for (int i = 0; i < 4; i++) step(1'b0, 4'b0101);

      // randomized traffic with sticky requests and occasional resets
      r = 4'b0000;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
         r = r ^ flip;
         step($urandom_range(0, 299) == 0, r);
      end

      step(1'b0, 4'b0000);
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
